// File: rtl/field_packer.sv
// field_packer: packs variable-length fields MSB-first into OUT_W-bit words with flush on in_last.
// Optional per-field inversion is compiled in with `define FIELD_PACKER_INV_EN.
module field_packer #(
    parameter  int OUT_W   = 8,
    parameter  int FIELD_W = 4,
    localparam int LEN_W   = $clog2(FIELD_W + 1),
    localparam int CNT_W   = $clog2(OUT_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_data,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_inv,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_bits,
    output logic               out_last
);

    typedef enum logic [1:0] {ACCUM, HOLD, HOLD_FLUSH} state_t;

    state_t                     state;
    logic [OUT_W-1:0]           acc;
    logic [CNT_W-1:0]           cnt;

    logic [LEN_W-1:0]           leff;
    logic [LEN_W-1:0]           lsh;
    logic [FIELD_W-1:0]         fsrc;
    logic [FIELD_W-1:0]         mask;
    logic [FIELD_W-1:0]         fbits;
    logic [FIELD_W-1:0]         falign;
    logic [OUT_W+FIELD_W-1:0]   wide;
    logic [OUT_W-1:0]           word;
    logic [OUT_W-1:0]           acc_rem;
    logic [CNT_W:0]             total;
    logic [CNT_W-1:0]           rem;

`ifdef FIELD_PACKER_INV_EN
    assign fsrc = in_inv ? ~in_data : in_data;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign fsrc       = in_data;
`endif

    assign in_ready = (state == ACCUM);

    // acc keeps held bits left-aligned; the new field lands just below them in a
    // window FIELD_W bits wider than a word so any overflow is kept as remainder.
    always_comb begin
        leff    = (in_len > LEN_W'(FIELD_W)) ? LEN_W'(FIELD_W) : in_len;
        mask    = ~({FIELD_W{1'b1}} << leff);
        fbits   = fsrc & mask;
        lsh     = LEN_W'(FIELD_W) - leff;
        falign  = fbits << lsh;
        wide    = {acc, {FIELD_W{1'b0}}} | ({falign, {OUT_W{1'b0}}} >> cnt);
        word    = wide[OUT_W+FIELD_W-1 -: OUT_W];
        acc_rem = OUT_W'(wide[FIELD_W-1:0]) << (OUT_W - FIELD_W);
        total   = (CNT_W+1)'(cnt) + (CNT_W+1)'(leff);
        rem     = CNT_W'(total - (CNT_W+1)'(OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bits  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (total >= (CNT_W+1)'(OUT_W)) begin
                            out_data  <= word;
                            out_bits  <= CNT_W'(OUT_W);
                            out_valid <= 1'b1;
                            acc       <= acc_rem;
                            cnt       <= rem;
                            // a leftover tail after the last field needs its own word
                            if (in_last && rem != '0) begin
                                out_last <= 1'b0;
                                state    <= HOLD_FLUSH;
                            end else begin
                                out_last <= in_last;
                                state    <= HOLD;
                            end
                        end else if (in_last) begin
                            acc <= '0;
                            cnt <= '0;
                            if (total != '0) begin
                                out_data  <= word;
                                out_bits  <= CNT_W'(total);
                                out_last  <= 1'b1;
                                out_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end else begin
                            acc <= word;
                            cnt <= CNT_W'(total);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                HOLD_FLUSH: begin
                    if (out_ready) begin
                        out_data <= acc;
                        out_bits <= cnt;
                        out_last <= 1'b1;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= HOLD;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: table vectors, directed multi-cycle sequences and a randomized run
// checked against a bit-queue model of the packer.
module tb_field_packer;

    localparam int OUT_W   = 8;
    localparam int FIELD_W = 4;
    localparam int LEN_W   = 3;
    localparam int CNT_W   = 4;
    localparam int NRAND   = 300;

`ifdef FIELD_PACKER_INV_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [FIELD_W-1:0] in_data;
    logic [LEN_W-1:0]   in_len;
    logic               in_inv;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [CNT_W-1:0]   out_bits;
    logic               out_last;

    field_packer #(.OUT_W(OUT_W), .FIELD_W(FIELD_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .in_inv(in_inv), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d;
        logic [2:0] l;
        logic       inv;
        logic [7:0] ed;
        logic [3:0] eb;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        logic [2:0] l;
        logic       inv;
        logic       last;
    } fld_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] b;
        logic       last;
    } wrd_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one field and holds it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] d, input logic [2:0] l, input logic inv,
                        input logic last, input string name);
        int n = 0;
        in_data = d; in_len = l; in_inv = inv; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk({name, " accept"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_inv = 1'b0;
    endtask

    task automatic take_word(input logic [7:0] d, input logic [3:0] b, input logic last,
                             input string name);
        chk({name, " valid"}, 32'(out_valid), 1);
        chk({name, " data"},  32'(out_data),  32'(d));
        chk({name, " bits"},  32'(out_bits),  32'(b));
        chk({name, " last"},  32'(out_last),  32'(last));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    fld_t flds[$];
    wrd_t expq[$];

    // Reference: flatten the packet into a bit queue, cut OUT_W-bit words, flush the tail.
    task automatic build_expected();
        bit   q[$];
        wrd_t w;
        int   len;
        int   n;
        foreach (flds[i]) begin
            len = (flds[i].l > 3'(FIELD_W)) ? FIELD_W : int'(flds[i].l);
            for (int k = len - 1; k >= 0; k--)
                q.push_back(flds[i].d[k] ^ (INV_ON & flds[i].inv));
            while (q.size() >= OUT_W) begin
                w.d = '0;
                for (int j = 0; j < OUT_W; j++) w.d[OUT_W-1-j] = q.pop_front();
                w.b = 4'(OUT_W);
                w.last = flds[i].last && (q.size() == 0);
                expq.push_back(w);
            end
            if (flds[i].last && q.size() > 0) begin
                n = q.size();
                w.d = '0;
                for (int j = 0; j < n; j++) w.d[OUT_W-1-j] = q.pop_front();
                w.b = 4'(n);
                w.last = 1'b1;
                expq.push_back(w);
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        fld_t f;
        int   exp_n;

        vecs[0] = '{4'h5, 3'd3, 1'b0, 8'hA0, 4'd3};
        vecs[1] = '{4'h9, 3'd7, 1'b0, 8'h90, 4'd4};
        vecs[2] = '{4'hF, 3'd1, 1'b0, 8'h80, 4'd1};
        vecs[3] = '{4'hE, 3'd2, 1'b0, 8'h80, 4'd2};
        vecs[4] = '{4'h3, 3'd4, 1'b1, INV_ON ? 8'hC0 : 8'h30, 4'd4};
        vecs[5] = '{4'h6, 3'd5, 1'b0, 8'h60, 4'd4};
        vecs[6] = '{4'h0, 3'd3, 1'b1, INV_ON ? 8'hE0 : 8'h00, 4'd3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; in_inv = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_data",  32'(out_data),  0);
        chk("reset out_bits",  32'(out_bits),  0);
        chk("reset out_last",  32'(out_last),  0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", 32'(in_ready), 1);

        // Single-field packets: partial flush, clamping, inversion
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].d, vecs[i].l, vecs[i].inv, 1'b1, $sformatf("vec%0d", i));
            take_word(vecs[i].ed, vecs[i].eb, 1'b1, $sformatf("vec%0d", i));
        end

        // Legacy layout, word presented the cycle after the last accept
        send(4'hD, 3'd4, 1'b0, 1'b0, "legacy f0");
        send(4'h1, 3'd2, 1'b0, 1'b0, "legacy f1");
        send(4'h0, 3'd1, 1'b1, 1'b0, "legacy f2");
        send(4'h1, 3'd1, 1'b0, 1'b1, "legacy f3");
        take_word(INV_ON ? 8'hD7 : 8'hD5, 4'd8, 1'b1, "legacy");

        // Overflow with last: full word then flushed tail
        send(4'hC, 3'd4, 1'b0, 1'b0, "ovf f0");
        send(4'h3, 3'd2, 1'b0, 1'b0, "ovf f1");
        send(4'hA, 3'd4, 1'b0, 1'b1, "ovf f2");
        chk("ovf in_ready w1", 32'(in_ready), 0);
        take_word(8'hCE, 4'd8, 1'b0, "ovf w1");
        chk("ovf in_ready w2", 32'(in_ready), 0);
        take_word(8'h80, 4'd2, 1'b1, "ovf w2");
        chk("ovf in_ready after", 32'(in_ready), 1);

        // Backpressure: stable outputs and in_ready low for the whole stall
        send(4'hF, 3'd4, 1'b0, 1'b0, "bp f0");
        send(4'hA, 3'd4, 1'b0, 1'b0, "bp f1");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp valid c%0d", i), 32'(out_valid), 1);
            chk($sformatf("bp data c%0d", i),  32'(out_data),  32'h FA);
            chk($sformatf("bp bits c%0d", i),  32'(out_bits),  8);
            chk($sformatf("bp last c%0d", i),  32'(out_last),  0);
            chk($sformatf("bp in_ready c%0d", i), 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp in_ready release", 32'(in_ready), 1);
        chk("bp valid release", 32'(out_valid), 0);

        // Zero-length last field on an empty accumulator emits nothing
        send(4'h0, 3'd0, 1'b0, 1'b1, "len0");
        chk("len0 valid", 32'(out_valid), 0);
        chk("len0 in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("len0 valid later", 32'(out_valid), 0);

        // Reset mid-packet discards the 6 held bits
        send(4'hF, 3'd4, 1'b0, 1'b0, "rstm f0");
        send(4'h3, 3'd2, 1'b0, 1'b0, "rstm f1");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstm out_valid", 32'(out_valid), 0);
        chk("rstm out_data",  32'(out_data),  0);
        chk("rstm out_bits",  32'(out_bits),  0);
        chk("rstm out_last",  32'(out_last),  0);
        chk("rstm in_ready",  32'(in_ready),  1);
        send(4'hF, 3'd4, 1'b0, 1'b0, "rstm g0");
        send(4'h0, 3'd4, 1'b0, 1'b1, "rstm g1");
        take_word(8'hF0, 4'd8, 1'b1, "rstm");

        // Randomized stream with random backpressure
        for (int i = 0; i < NRAND; i++) begin
            f.d    = 4'($urandom);
            f.l    = 3'($urandom_range(0, 7));
            f.inv  = 1'($urandom);
            f.last = ($urandom_range(0, 4) == 0) || (i == NRAND - 1);
            flds.push_back(f);
        end
        build_expected();
        exp_n = expq.size();

        fork
            begin
                int  budget = 20000;
                bit  got;
                foreach (flds[i]) begin
                    in_data = flds[i].d; in_len = flds[i].l; in_inv = flds[i].inv;
                    in_last = flds[i].last; in_valid = 1'b1;
                    do begin
                        @(negedge clk);
                        got = in_ready;
                        @(posedge clk); #1;
                        budget--;
                    end while (!got && budget > 0);
                    in_valid = 1'b0; in_last = 1'b0;
                    if (budget <= 0) break;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                int   got_n = 0;
                int   cyc = 0;
                wrd_t w;
                while (got_n < exp_n && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        w = expq.pop_front();
                        chk($sformatf("rand w%0d data", got_n), 32'(out_data), 32'(w.d));
                        chk($sformatf("rand w%0d bits", got_n), 32'(out_bits), 32'(w.b));
                        chk($sformatf("rand w%0d last", got_n), 32'(out_last), 32'(w.last));
                        got_n++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b0;
                chk("rand word count", 32'(got_n), 32'(exp_n));
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/field_packer.md
# field_packer

Sequential, parametrised bit-field packer that concatenates a stream of variable-length fields MSB-first into OUT_W-bit words. It generalises fixed concat-style packing (e.g. {A,B,~C,D}) to arbitrary field widths and counts, with per-field inversion, valid/ready handshakes on both sides and packet flush. It sits between field producers (header builders, control encoders) and any word-wide sink or FIFO.

## Interface
- OUT_W, 8, output word width; OUT_W >= FIELD_W >= 1.
- FIELD_W, 4, maximum field width.
- LEN_W (localparam), $clog2(FIELD_W+1), field-length width.
- CNT_W (localparam), $clog2(OUT_W+1), output bit-count width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field present.
- in_ready  out  1  packer accepts a field this cycle.
- in_data  in  FIELD_W  field bits; the low in_len bits are used, in_data[in_len-1] goes first.
- in_len  in  LEN_W  field length; 0 means no bits; values above FIELD_W are clamped to FIELD_W.
- in_inv  in  1  invert field bits before packing; only active with the macro defined.
- in_last  in  1  final field of the packet; flush after it.
- out_valid  out  1  word present.
- out_ready  in  1  sink accepts the word.
- out_data  out  OUT_W  packed word, left-aligned, with unused low bits 0.
- out_bits  out  CNT_W  number of valid bits: OUT_W for a full word, 1..OUT_W-1 for a flushed partial word.
- out_last  out  1  word carries the last bit of a packet.

## Operation
- State: an OUT_W-bit accumulator acc, fill count cnt (0..OUT_W-1) and a 3-state FSM: ACCUM, HOLD, HOLD_FLUSH.
- Accept: a field is accepted on in_valid & in_ready. Effective length L = min(in_len, FIELD_W). Bits are appended below the cnt bits already held in acc.
- ACCUM, accept, cnt+L < OUT_W, !in_last: acc and cnt update. No output.
- ACCUM, accept, cnt+L >= OUT_W: the full word is loaded to out_data with out_bits=OUT_W, and the remainder R = cnt+L-OUT_W bits are left-aligned in acc with cnt=R.
  - If !in_last: go to HOLD with out_last=0.
  - If in_last and R=0: go to HOLD with out_last=1.
  - If in_last and R>0: go to HOLD_FLUSH with out_last=0.
- ACCUM, accept, in_last, cnt+L < OUT_W:
  - If cnt+L > 0: load the partial word with out_bits=cnt+L and out_last=1, clear acc and cnt, and go to HOLD.
  - If cnt+L = 0: emit no word and stay in ACCUM.
- HOLD: out_valid=1. When out_ready is high, go to ACCUM.
- HOLD_FLUSH: out_valid=1. When out_ready is high, load the partial word (acc, out_bits=cnt, out_last=1), clear acc and cnt, and go to HOLD.
- Packet boundary: after any word with out_last=1, cnt=0 and the next packet starts word-aligned.

## Timing
- in_ready = (state==ACCUM). It is driven from registered state only, with no combinational path from out_ready.
- out_data, out_bits, out_last and out_valid are registered.
- Latency: a word completed by a field accepted in cycle N is presented with out_valid=1 in cycle N+1.
- Throughput:
  - One field per cycle while no word completes.
  - Each completed word costs at least one extra cycle (HOLD).
- Backpressure:
  - While out_valid=1 and out_ready=0, all output registers hold stable.
  - in_ready stays 0 for the whole stall.
- Reset value of every output: out_valid=0, out_data=0, out_bits=0, out_last=0. in_ready=1 from the first cycle after reset.
- Reset mid-packet discards acc, cnt and any pending word. Reset wins over a simultaneous transfer.

## Configuration
- FIELD_PACKER_INV_EN
  - Defined: when in_inv=1, the L used bits of the field are bitwise inverted before packing. Unused bits are ignored either way.
  - Undefined: in_inv is ignored (port kept, no logic), and fields pack unmodified.

## Test plan
- Legacy layout (OUT_W=8, FIELD_W=4, macro defined): fields (1101,L4), (01,L2), (0,L1,inv=1), (1,L1,last) with out_ready=1 -> one word out_data=8'hD7, out_bits=8, out_last=1, presented 1 cycle after the last accept.
- Partial flush: (101,L3,last) -> out_data=8'hA0, out_bits=3, out_last=1.
- Overflow with last: (1100,L4), (11,L2), (1010,L4,last):
  - First: out_data=8'hCE, out_bits=8, out_last=0.
  - Then: out_data=8'h80, out_bits=2, out_last=1, in_ready low until both words are taken.
- Backpressure: complete a word, hold out_ready=0 for 5 cycles -> out_data/out_bits/out_last stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
- Length edges:
  - in_len=7 with FIELD_W=4 packs 4 bits.
  - in_len=0 with in_last on an empty accumulator -> no word emitted, in_ready stays 1.
- Reset mid-packet: accumulate 6 bits, assert rst one cycle -> all outputs 0. Next packet (1111,L4),(0000,L4) -> out_data=8'hF0, proving no stale bits.
